nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial adder controller around one 4-bit ripple-carry adder

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q, b_q, part_q, sum_q;
    logic            carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [3:0]      add_a, add_b, add_sum;
    logic            add_cout;
    logic [W-1:0]    result_d;
    logic            ovf_d;

    always_comb begin
        add_a = a_q[4*idx_q +: 4];
        add_b = b_q[4*idx_q +: 4];
    end

    ripple_carry_adder u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Partial result with the nibble being computed this cycle already merged in.
    always_comb begin
        result_d = part_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                result_d[4*n +: 4] = add_sum;
            end
        end
        ovf_d = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        part_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    part_q  <= result_d;
                    carry_q <= add_cout;
                    if (idx_q == LAST) begin
                        sum_q   <= result_d;
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench for nibble_serial_add_ctrl

module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;

    logic [15:0] prev_sum;
    logic        prev_cout, prev_ovf;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_add(input logic [15:0] ta, input logic [15:0] tb2, input logic tc, input bit disturb);
        logic [16:0] full;
        logic        exp_ovf;
        int          busy_cnt;
        int          done_cyc;
        full    = {1'b0, ta} + {1'b0, tb2} + {16'd0, tc};
        exp_ovf = (ta[15] == tb2[15]) && (full[15] != ta[15]);
        @(negedge clk);
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (disturb && cyc == 2) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            end
            if (disturb && cyc == 3) start = 1'b0;
            if (cyc == 1) begin
                check_eq("hold_sum", {16'd0, sum}, {16'd0, prev_sum});
                check_eq("hold_flags", {30'd0, cout, ovf}, {30'd0, prev_cout, prev_ovf});
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc < 12) @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_latency", done_cyc, 5);
        check_eq("busy_cycles", busy_cnt, 4);
        check_eq("sum", {16'd0, sum}, {16'd0, full[15:0]});
        check_eq("cout", {31'd0, cout}, {31'd0, full[16]});
        check_eq("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        prev_sum  = full[15:0];
        prev_cout = full[16];
        prev_ovf  = exp_ovf;
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        #1;
        check_eq("reset_outs", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        do_add(16'h000E, 16'h0001, 1'b0, 1'b0);
        do_add(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        do_add(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_add(16'h8000, 16'h8000, 1'b0, 1'b0);
        do_add(16'h1234, 16'h1111, 1'b0, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("async_reset_outs", {13'd0, busy, done, cout, ovf, sum}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check_eq("no_done_after_abort", seen_done, 0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        do_add(16'h0003, 16'h0004, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            do_add(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
